shift_exec_pipe: RTL and testbench
==================================

// Module: shift_exec_pipe
// PURPOSE
//  Two-stage pipelined shift/rotate execution unit for the RV32I datapath.
//  Takes a shift op from issue, rotates via a barrel_rotate_bidir instance, then masks/sign-fills to
//  produce SLL/SRL/SRA/ROR results. Drives the writeback mux with its own valid/ready handshake.
//  Holds full throughput of one op per cycle under backpressure.
// PARAMETERS
//  BitWidth   32  operand/result width; power of two, >= 4
//  TagWidth   5   destination tag width (rd index), passed through unchanged
// PORTS
//  clk        in   1                  rising-edge clock
//  rst        in   1                  synchronous, active-high reset
//  flush      in   1                  synchronous pipeline clear (pipeline redirect)
//  in_valid   in   1                  upstream op valid
//  in_ready   out  1                  unit can accept op this cycle
//  in_op      in   2                  00 SLL, 01 SRL, 10 ROR, 11 SRA
//  in_data    in   BitWidth           operand to shift
//  in_shamt   in   $clog2(BitWidth)   shift amount
//  in_tag     in   TagWidth           destination tag
//  out_valid  out  1                  result valid
//  out_ready  in   1                  downstream accepts result
//  out_data   out  BitWidth           shift/rotate result
//  out_tag    out  TagWidth           tag of out_data
//  busy       out  1                  either stage holds a valid op
// BEHAVIOUR
//  - One clock domain. rst is synchronous and active-high; it takes priority over every other input.
//  - Reset: s1_valid=0, s2_valid=0. Outputs are out_valid=0, out_data=0, out_tag=0, busy=0.
//    in_ready=0 while rst is high.
//  - Handshakes: transfer on valid&ready. Once out_valid is high, out_data and out_tag hold stable
//    until out_ready is sampled high.
//  - Stage advance: s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv;
//    in_ready = s1_adv & !rst. in_ready is combinational.
//  - Stage 1 (accept edge): register the rotated value, op, shamt, in_data[BitWidth-1] (sign) and tag.
//    Rotator direction: left for SLL; right for SRL/ROR/SRA.
//  - Stage 2 (on s2_adv): apply the mask and register the result into out_data.
//      SLL: rot & (~0 << shamt)
//      SRL: rot & (~0 >> shamt)
//      ROR: rot
//      SRA: (rot & (~0 >> shamt)) | (sign ? ~(~0 >> shamt) : 0)
//  - Width rules: shamt is unsigned 0..BitWidth-1. shamt=0 returns in_data for every op.
//    No carry or overflow output.
//  - Latency: exactly 2 cycles from the accept edge to out_valid when out_ready stays high.
//    Throughput is 1 op/cycle.
//  - Backpressure: if out_ready is low and s2 is full, s2 holds. s1 fills, then in_ready drops.
//    Ops are never dropped, duplicated or reordered.
//  - Simultaneous events: s2 drain and s1->s2 move and new accept can all happen on one edge.
//    flush wins over accept: an op offered in the flush cycle is not captured, even if in_ready was high.
//  - flush: clears s1_valid and s2_valid next edge; the result presented that cycle is discarded
//    even if out_ready=1. Data regs need not clear on flush.
//  - Reset mid-operation: all in-flight ops are discarded; no out_valid follows reset deassert
//    until a new accept.
//  - busy = s1_valid | s2_valid.
//  - The stage 1 rotate output is mux-free of stage 2 logic. Critical path is rotator only
//    in stage 1, masking only in stage 2.
// TESTING
//  1. rst held 2 cycles mid-stream (in_valid=1) -> out_valid=0, out_data=0, busy=0; in_ready=1 on first cycle after deassert.
//  2. SLL 0x8000_0001 shamt=1 tag=3 -> 2 cycles later out_data=0x0000_0002, out_tag=3; SRL 0x8000_0000 shamt=31 -> 0x0000_0001.
//  3. SRA 0x8000_0000 shamt=31 -> 0xFFFF_FFFF; SRA 0x7FFF_FFF0 shamt=4 -> 0x07FF_FFFF; shamt=0 any op on 0xDEAD_BEEF -> 0xDEAD_BEEF.
//  4. ROR 0x0000_0001 shamt=1 -> 0x8000_0000; ROR 0x1234_5678 shamt=8 -> 0x7812_3456.
//  5. Ops A,B,C back-to-back with out_ready=0 -> A,B accepted, in_ready=0 on C; release out_ready -> results A,B,C in order, one per cycle, stable while stalled.
//  6. flush with both stages full and new op offered -> next cycle out_valid=0, busy=0, offered op never appears; random compare vs reference model, 10k ops, random out_ready.

Source files
------------

// File: rtl/shift_exec_pipe.sv
// rtl/shift_exec_pipe.sv - two-stage SLL/SRL/ROR/SRA execution unit with valid/ready handshakes
// Stage 1 rotates only; stage 2 masks and sign-fills the rotated value into the result register.

module barrel_rotate_bidir #(
  parameter int BitWidth   = 32,
  parameter int ShamtWidth = $clog2(BitWidth)
) (
  input  logic [BitWidth-1:0]   rot_in,
  input  logic [ShamtWidth-1:0] rot_amt,
  input  logic                  rot_left,
  output logic [BitWidth-1:0]   rot_out
);

  logic [BitWidth-1:0] stage;

  // One log2 stage per shift-amount bit; each stage rotates by a fixed power of two.
  always_comb begin
    stage = rot_in;
    for (int i = 0; i < ShamtWidth; i++) begin
      if (rot_amt[i]) begin
        if (rot_left) begin
          stage = (stage << (1 << i)) | (stage >> (BitWidth - (1 << i)));
        end else begin
          stage = (stage >> (1 << i)) | (stage << (BitWidth - (1 << i)));
        end
      end
    end
    rot_out = stage;
  end

endmodule

module shift_exec_pipe #(
  parameter int BitWidth = 32,
  parameter int TagWidth = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_op,
  input  logic [BitWidth-1:0]           in_data,
  input  logic [$clog2(BitWidth)-1:0]   in_shamt,
  input  logic [TagWidth-1:0]           in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BitWidth-1:0]           out_data,
  output logic [TagWidth-1:0]           out_tag,
  output logic                          busy
);

  localparam int ShamtWidth = $clog2(BitWidth);
  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpRor = 2'b10;
  localparam logic [1:0] OpSra = 2'b11;

  logic                  s1_valid_q, s1_valid_d;
  logic [BitWidth-1:0]   s1_rot_q, s1_rot_d;
  logic [1:0]            s1_op_q, s1_op_d;
  logic [ShamtWidth-1:0] s1_shamt_q, s1_shamt_d;
  logic                  s1_sign_q, s1_sign_d;
  logic [TagWidth-1:0]   s1_tag_q, s1_tag_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [BitWidth-1:0]   out_data_q, out_data_d;
  logic [TagWidth-1:0]   out_tag_q, out_tag_d;

  logic                  s1_adv, s2_adv, accept;
  logic [BitWidth-1:0]   rot_val, mask_l, mask_r, masked;

  barrel_rotate_bidir #(
    .BitWidth   (BitWidth),
    .ShamtWidth (ShamtWidth)
  ) u_rot (
    .rot_in   (in_data),
    .rot_amt  (in_shamt),
    .rot_left (in_op == OpSll),
    .rot_out  (rot_val)
  );

  always_comb begin
    mask_l = {BitWidth{1'b1}} << s1_shamt_q;
    mask_r = {BitWidth{1'b1}} >> s1_shamt_q;
    masked = s1_rot_q;
    case (s1_op_q)
      OpSll:   masked = s1_rot_q & mask_l;
      OpSrl:   masked = s1_rot_q & mask_r;
      OpRor:   masked = s1_rot_q;
      OpSra:   masked = (s1_rot_q & mask_r) | (s1_sign_q ? ~mask_r : '0);
      default: masked = s1_rot_q;
    endcase
  end

  always_comb begin
    s2_adv   = !s2_valid_q | out_ready;
    s1_adv   = !s1_valid_q | s2_adv;
    in_ready = s1_adv & !rst;
    // flush beats a same-cycle offer even though in_ready is not gated by it.
    accept   = in_valid & in_ready & !flush;

    s1_valid_d = s1_valid_q;
    s1_rot_d   = s1_rot_q;
    s1_op_d    = s1_op_q;
    s1_shamt_d = s1_shamt_q;
    s1_sign_d  = s1_sign_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;

    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (s1_adv) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_rot_d   = rot_val;
      s1_op_d    = in_op;
      s1_shamt_d = in_shamt;
      s1_sign_d  = in_data[BitWidth-1];
      s1_tag_d   = in_tag;
    end

    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_adv & s1_valid_q & !flush) begin
      out_data_d = masked;
      out_tag_d  = s1_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_rot_q   <= '0;
      s1_op_q    <= '0;
      s1_shamt_q <= '0;
      s1_sign_q  <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_rot_q   <= s1_rot_d;
      s1_op_q    <= s1_op_d;
      s1_shamt_q <= s1_shamt_d;
      s1_sign_q  <= s1_sign_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_shift_exec_pipe.sv
// tb/tb_shift_exec_pipe.sv - self-checking bench for shift_exec_pipe against a queue-based reference
// The reference computes results with plain arithmetic and tracks in-flight ops as an ordered queue.

module tb_shift_exec_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]  in_op;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt, in_tag, out_tag;

  int checks = 0;
  int errors = 0;
  int accepted = 0;

  logic [31:0] exp_data_q[$];
  logic [4:0]  exp_tag_q[$];
  logic        hold_pending = 1'b0;
  logic [31:0] hold_data;
  logic [4:0]  hold_tag;

  shift_exec_pipe #(.BitWidth(32), .TagWidth(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] s);
    logic [63:0] both;
    both = {d, d} >> s;
    case (op)
      2'd0:    return d << s;
      2'd1:    return d >> s;
      2'd2:    return both[31:0];
      default: return $unsigned($signed(d) >>> s);
    endcase
  endfunction

  // Called at a negedge with inputs already driven; predicts this cycle's edge, then advances.
  task automatic tick();
    #1;
    check("in_ready", in_ready, rst ? 1'b0 : ((exp_data_q.size() < 2) || out_ready));
    check("busy", busy, exp_data_q.size() != 0);
    if (exp_data_q.size() == 2) check("full_out_valid", out_valid, 1'b1);
    if (out_valid && exp_data_q.size() == 0) check("orphan_out_valid", out_valid, 1'b0);
    if (hold_pending) begin
      check("hold_data", out_data, hold_data);
      check("hold_tag", out_tag, hold_tag);
    end
    hold_pending = out_valid && !out_ready && !flush && !rst;
    hold_data = out_data;
    hold_tag = out_tag;
    if (rst || flush) begin
      exp_data_q.delete();
      exp_tag_q.delete();
    end else begin
      if (out_valid && out_ready && exp_data_q.size() != 0) begin
        check("out_data", out_data, exp_data_q.pop_front());
        check("out_tag", out_tag, exp_tag_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_data_q.push_back(ref_shift(in_op, in_data, in_shamt));
        exp_tag_q.push_back(in_tag);
        accepted++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                       input logic [4:0] t);
    in_valid = 1'b1;
    in_op = op;
    in_data = d;
    in_shamt = s;
    in_tag = t;
  endtask

  task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] s, input logic [4:0] t, input logic [31:0] exp);
    out_ready = 1'b1;
    drive(op, d, s, t);
    tick();
    in_valid = 1'b0;
    check({name, "_lat1"}, out_valid, 1'b0);
    tick();
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_data"}, out_data, exp);
    check({name, "_tag"}, out_tag, t);
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_data = '0; in_shamt = '0; in_tag = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_tag", out_tag, 5'h0);
    check("rst_busy", busy, 1'b0);

    run_one("sll1", 2'd0, 32'h8000_0001, 5'd1, 5'd3, 32'h0000_0002);
    run_one("srl31", 2'd1, 32'h8000_0000, 5'd31, 5'd4, 32'h0000_0001);
    run_one("sra31", 2'd3, 32'h8000_0000, 5'd31, 5'd5, 32'hFFFF_FFFF);
    run_one("sra4", 2'd3, 32'h7FFF_FFF0, 5'd4, 5'd6, 32'h07FF_FFFF);
    for (int op = 0; op < 4; op++) run_one("shamt0", 2'(op), 32'hDEAD_BEEF, 5'd0, 5'(op), 32'hDEAD_BEEF);
    run_one("ror1", 2'd2, 32'h0000_0001, 5'd1, 5'd7, 32'h8000_0000);
    run_one("ror8", 2'd2, 32'h1234_5678, 5'd8, 5'd8, 32'h7812_3456);

    // Reset mid-stream with both stages loaded and an op still offered.
    out_ready = 1'b0;
    drive(2'd0, 32'h1, 5'd1, 5'd9);
    tick();
    drive(2'd1, 32'h80, 5'd2, 5'd10);
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_data", out_data, 32'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Backpressure: A, B fill the pipe, C waits until out_ready returns.
    out_ready = 1'b0;
    drive(2'd0, 32'h0000_0001, 5'd4, 5'd11);
    tick();
    drive(2'd2, 32'h1234_5678, 5'd8, 5'd12);
    tick();
    drive(2'd3, 32'h8000_0000, 5'd4, 5'd13);
    #1;
    check("bp_c_in_ready", in_ready, 1'b0);
    tick();
    tick();
    check("bp_stall_data", out_data, 32'h0000_0010);
    out_ready = 1'b1;
    #1;
    check("bp_c_in_ready_rel", in_ready, 1'b1);
    check("bp_a_valid", out_valid, 1'b1);
    check("bp_a_data", out_data, 32'h0000_0010);
    tick();
    in_valid = 1'b0;
    check("bp_b_valid", out_valid, 1'b1);
    check("bp_b_data", out_data, 32'h7812_3456);
    tick();
    check("bp_c_valid", out_valid, 1'b1);
    check("bp_c_data", out_data, 32'hF800_0000);
    check("bp_c_tag", out_tag, 5'd13);
    tick();
    check("bp_empty", out_valid, 1'b0);

    // Flush with both stages full and a new op offered.
    out_ready = 1'b0;
    drive(2'd0, 32'h3, 5'd1, 5'd14);
    tick();
    drive(2'd1, 32'hF0, 5'd4, 5'd15);
    tick();
    drive(2'd2, 32'hAAAA_5555, 5'd3, 5'd16);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_no_ghost", out_valid, 1'b0);
    end

    // Random traffic with random backpressure and occasional flushes.
    accepted = 0;
    for (int cyc = 0; cyc < 60000 && accepted < 10000; cyc++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_op = 2'($urandom_range(0, 3));
      in_data = $urandom;
      case ($urandom_range(0, 7))
        0:       in_shamt = 5'd0;
        1:       in_shamt = 5'd31;
        default: in_shamt = 5'($urandom_range(0, 31));
      endcase
      in_tag = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 99) == 0);
      tick();
    end
    check("random_ops_done", accepted >= 10000, 1'b1);
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_data_q.size() != 0; i++) tick();
    check("drain_empty", exp_data_q.size(), 0);
    check("drain_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
